// File: rtl/lfsr_stream_encryptor.sv
// Frame-based stream encryptor: bias-subtracted characters XORed with a Fibonacci
// LFSR keystream, framed as preamble + message + pad to a fixed length.
module lfsr_stream_encryptor #(
   parameter int                LFSR_W    = 7,
   parameter int                DATA_W    = 8,
   parameter int                MSG_LEN   = 64,
   parameter int                PRE_MIN   = 10,
   parameter int                PRE_MAX   = 26,
   parameter logic [DATA_W-1:0] BIAS      = 8'h20,
   parameter bit                PARITY_EN = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        pre_length,
   input  logic [LFSR_W-1:0] taps,
   input  logic [LFSR_W-1:0] seed,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [2:0]        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // out_valid/out_data/out_last hold until that transfer, in_ready never depends on in_valid.
   typedef enum logic [2:0] {IDLE, PREAMBLE, MESSAGE, PAD, DONE} state_t;

   localparam int CNT_W = ($clog2(MSG_LEN + 1) > 8) ? $clog2(MSG_LEN + 1) : 8;

   state_t            state, state_nx;
   logic [LFSR_W-1:0] lfsr, lfsr_nx, taps_q;
   logic [CNT_W-1:0]  count, pre_len;
   logic [7:0]        pre_clamped;
   logic [DATA_W-1:0] char_in, diff, enc;
   logic              free, load, last_char, set_ovf, start_acc;

   assign free      = !out_valid || out_ready;
   assign last_char = (count == CNT_W'(MSG_LEN - 1));
   assign in_ready  = (state == MESSAGE) && free;
   assign busy      = (state == PREAMBLE) || (state == MESSAGE) || (state == PAD);
   assign dbg_state = state;
   assign lfsr_nx   = {lfsr[LFSR_W-2:0], ^(lfsr & taps_q)};
   assign diff      = char_in - BIAS;

   always_comb begin
      pre_clamped = pre_length;
      if (pre_length < 8'(PRE_MIN))
         pre_clamped = 8'(PRE_MIN);
      else if (pre_length > 8'(PRE_MAX))
         pre_clamped = 8'(PRE_MAX);
   end

   // Keystream is the current LFSR state; the MSB is then replaced by parity or 0.
   always_comb begin
      enc = diff ^ DATA_W'(lfsr);
      enc[DATA_W-1] = PARITY_EN ? ^enc[DATA_W-2:0] : 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      load      = 1'b0;
      char_in   = BIAS;
      set_ovf   = 1'b0;
      start_acc = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = PREAMBLE;
            end
         end
         PREAMBLE: begin
            if (free) begin
               load = 1'b1;
               if (count == pre_len - 1'b1)
                  state_nx = MESSAGE;
            end
         end
         MESSAGE: begin
            if (free && in_valid) begin
               load    = 1'b1;
               char_in = in_data;
               if (last_char) begin
                  state_nx = DONE;
                  set_ovf  = !in_last;
               end else if (in_last) begin
                  state_nx = PAD;
               end
            end
         end
         PAD: begin
            if (free) begin
               load = 1'b1;
               if (last_char)
                  state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr      <= '0;
         taps_q    <= '0;
         count     <= '0;
         pre_len   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (start_acc) begin
            taps_q   <= taps;
            lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
            pre_len  <= CNT_W'(pre_clamped);
            count    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
         end
         if (load) begin
            out_data  <= enc;
            out_last  <= last_char;
            out_valid <= 1'b1;
            lfsr      <= lfsr_nx;
            count     <= count + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         if (set_ovf)
            overflow <= 1'b1;
         // done waits until the last loaded character has left the output register.
         if (state == DONE && !start && free)
            done <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lfsr_stream_encryptor.sv
// Bench for lfsr_stream_encryptor: reference keystream model feeding an expected queue,
// checked against two instances (parity off and parity on) sharing the same stimulus.
module tb_lfsr_stream_encryptor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] pre_length;
   logic [6:0] taps, seed;
   logic       in_valid, in_last, out_ready;
   logic [7:0] in_data;

   logic       in_ready, out_valid, out_last, busy, done, overflow;
   logic [7:0] out_data;
   logic [2:0] dbg_state;
   logic       in_ready_p, out_valid_p, out_last_p, busy_p, done_p, overflow_p;
   logic [7:0] out_data_p;
   logic [2:0] dbg_state_p;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [8:0] exp_p_q[$];
   logic [6:0] m_lfsr, m_taps;
   int         m_count;
   int         n_out, n_out_p;
   logic [7:0] got[64];
   logic [7:0] got_p[64];
   logic [7:0] msg[64];
   logic [7:0] ref_tab[11];

   always #5 clk = ~clk;

   lfsr_stream_encryptor dut (
      .clk(clk), .reset(rst_n), .start(start), .pre_length(pre_length),
      .taps(taps), .seed(seed), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .overflow(overflow), .dbg_state(dbg_state)
   );

   lfsr_stream_encryptor #(.PARITY_EN(1'b1)) dut_p (
      .clk(clk), .reset(rst_n), .start(start), .pre_length(pre_length),
      .taps(taps), .seed(seed), .in_valid(in_valid), .in_ready(in_ready_p),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid_p),
      .out_ready(out_ready), .out_data(out_data_p), .out_last(out_last_p),
      .busy(busy_p), .done(done_p), .overflow(overflow_p), .dbg_state(dbg_state_p)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_enc(input logic [7:0] c, input logic [6:0] s, input bit par);
      logic [7:0] d;
      d = (c - 8'h20) ^ {1'b0, s};
      d[7] = par ? ^d[6:0] : 1'b0;
      return d;
   endfunction

   task automatic model_emit(input logic [7:0] c);
      logic lst;
      lst = (m_count == 63);
      exp_q.push_back({lst, model_enc(c, m_lfsr, 1'b0)});
      exp_p_q.push_back({lst, model_enc(c, m_lfsr, 1'b1)});
      m_lfsr = {m_lfsr[5:0], ^(m_lfsr & m_taps)};
      m_count++;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0)
            check("extra_out", 1, 0);
         else
            check("out", {out_last, out_data}, exp_q.pop_front());
         if (n_out < 64) got[n_out] = out_data;
         n_out++;
      end
      if (rst_n && out_valid_p && out_ready) begin
         if (exp_p_q.size() == 0)
            check("extra_out_p", 1, 0);
         else
            check("out_p", {out_last_p, out_data_p}, exp_p_q.pop_front());
         if (n_out_p < 64) got_p[n_out_p] = out_data_p;
         n_out_p++;
      end
   end

   task automatic start_frame(input logic [6:0] sd, input logic [6:0] tp, input logic [7:0] pl,
                              input int pre_exp);
      @(posedge clk); #1;
      start = 1'b1; seed = sd; taps = tp; pre_length = pl;
      m_taps = tp;
      m_lfsr = (sd == 7'd0) ? 7'd1 : sd;
      m_count = 0; n_out = 0; n_out_p = 0;
      for (int i = 0; i < pre_exp; i++) model_emit(8'h20);
      @(posedge clk); #1;
      start = 1'b0;
      check("start_busy", busy, 1);
      check("lat_none", out_valid, 0);
      @(posedge clk); #1;
      check("lat_first", out_valid, 1);
   endtask

   task automatic send_msg(input int n, input bit with_last, input int stall_at, output int accepted);
      bit ok;
      accepted = 0;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = msg[i];
         in_last  = with_last && (i == n - 1);
         ok = 1'b0;
         for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
         end
         if (!ok) break;
         @(posedge clk); #1;
         accepted++;
         model_emit(msg[i]);
         if (in_last)
            while (m_count < 64) model_emit(8'h20);
         if (i == stall_at) begin
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input bit exp_ovf);
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (done) break;
      end
      check("done", done, 1);
      check("done_p", done_p, 1);
      check("overflow", overflow, exp_ovf);
      check("busy_end", busy, 0);
      check("in_ready_end", in_ready, 0);
      check("n_out", n_out, 64);
      check("n_out_p", n_out_p, 64);
      check("q_empty", exp_q.size() + exp_p_q.size(), 0);
   endtask

   task automatic check_ref_table();
      for (int i = 0; i < 11; i++) check("ref_char", got[i], ref_tab[i]);
   endtask

   initial begin
      int acc;
      logic [7:0] held;
      int valid_seen;
      ref_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03, 8'h06, 8'h0C, 8'h38};
      rst_n = 1'b0; start = 1'b0; pre_length = 8'd0; taps = 7'd0; seed = 7'd0;
      in_valid = 1'b0; in_last = 1'b0; in_data = 8'd0; out_ready = 1'b1;
      n_out = 0; n_out_p = 0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_flags", {busy, done, overflow, in_ready, out_last}, 0);
      check("rst_state", dbg_state, 0);
      @(negedge clk); rst_n = 1'b1;

      // Reference frame: one '@' character
      msg[0] = 8'h40;
      start_frame(7'h01, 7'h60, 8'd10, 10);
      send_msg(1, 1'b1, -1, acc);
      check("acc_ref", acc, 1);
      wait_done(1'b0);
      check_ref_table();
      check("par_c0", got_p[0], 8'h81);
      check("par_c1", got_p[1], 8'h82);
      check("par_c10", got_p[10], 8'hB8);

      // Seed 0 behaves as seed 1; short preamble clamps up to 10
      start_frame(7'h00, 7'h60, 8'd5, 10);
      send_msg(1, 1'b1, -1, acc);
      wait_done(1'b0);
      check_ref_table();

      // Long preamble clamps down to 26, random message, other taps
      for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(0, 255));
      start_frame(7'h2B, 7'h41, 8'd40, 26);
      send_msg(6, 1'b1, -1, acc);
      check("acc_clamp", acc, 6);
      wait_done(1'b0);

      // Output and input stalls
      start_frame(7'h15, 7'h60, 8'd12, 12);
      fork
         send_msg(20, 1'b1, 5, acc);
         begin
            for (int t = 0; t < 500; t++) begin
               @(negedge clk);
               if (n_out >= 12) break;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            held = out_data;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check("stall_valid", out_valid, 1);
               check("stall_hold", out_data, held);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      check("acc_stall", acc, 20);
      wait_done(1'b0);

      // Overflow: message without in_last
      start_frame(7'h33, 7'h60, 8'd26, 26);
      send_msg(40, 1'b0, -1, acc);
      check("acc_ovf", acc, 38);
      wait_done(1'b1);
      check("ovf_p", overflow_p, 1);

      // Reset during char 20
      start_frame(7'h01, 7'h60, 8'd26, 26);
      for (int t = 0; t < 500; t++) begin
         @(negedge clk);
         if (n_out >= 20) break;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_flags", {busy, done, overflow, in_ready, out_last}, 0);
      check("mid_rst_state", dbg_state, 0);
      exp_q.delete();
      exp_p_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      valid_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) valid_seen++;
      end
      check("post_rst_quiet", valid_seen, 0);

      start_frame(7'h01, 7'h60, 8'd10, 10);
      msg[0] = 8'h40;
      send_msg(1, 1'b1, -1, acc);
      wait_done(1'b0);
      check_ref_table();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
